multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM that sequences the CPU datapath (PC, instruction memory/data memory port, register file, ALU) one phase per clock, replacing the single-cycle always-advance PC. Decodes opcode/funct fields from the latched instruction, drives ALU control and all write enables, handshakes with memory via `mem_ready`, and handles halt (one-cycle `createdump` pulse) and illegal/timeout errors. Also counts retired instructions.

## Interface
- `MEM_TIMEOUT`, 15, max cycles spent waiting for `mem_ready` in FETCH or MEM before ERROR (≥1)
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  7  instruction[6:0] from instruction register
- `funct3`  in  3  instruction[14:12]
- `funct7_5`  in  1  instruction[30]
- `is_halt`  in  1  halt decode of current instruction
- `mem_ready`  in  1  memory completed the current access this cycle
- `mem_en`  out  1  memory access enable
- `mem_wr`  out  1  memory write (store)
- `addr_sel`  out  1  memory address source: 0 = PC, 1 = ALU result
- `ir_we`  out  1  latch memory data into instruction register
- `pc_we`  out  1  PC <= PC + 4
- `rf_we`  out  1  register-file write
- `wb_sel`  out  1  write-back data: 0 = ALU result, 1 = memory data
- `alu_src_b`  out  1  ALU operand B: 0 = rs2, 1 = immediate
- `alu_control`  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT
- `createdump`  out  1  one-cycle pulse on halt
- `halted`  out  1  sticky; core stopped (HALT or ERROR)
- `error`  out  1  sticky; illegal instruction or memory timeout
- `state`  out  3  current state encoding (debug)
- `instret`  out  32  retired-instruction count

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, DUMP=5, HALT=6, ERROR=7.
- FETCH: `mem_en`=1, `addr_sel`=0. On `mem_ready`: `ir_we`=1 (same cycle, Mealy), go DECODE.
- DECODE: `is_halt` → DUMP (takes priority over opcode). Opcode 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store) → EXEC. Any other opcode, or R/I with funct3=011 → ERROR.
- EXEC: `alu_control` from decode; `alu_src_b`=1 for I/load/store, 0 for R. R/I → WB; load/store → MEM.
- ALU mapping (R/I): funct3 000→ADD (SUB if R and `funct7_5`=1), 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND. Load/store → ADD.
- MEM: `mem_en`=1, `addr_sel`=1, `alu_control`=ADD, `alu_src_b`=1; `mem_wr`=1 for store. On `mem_ready`: load → WB; store → FETCH with `pc_we`=1 that cycle.
- WB: `rf_we`=1, `pc_we`=1; `wb_sel`=1 for load, else 0 → FETCH.
- DUMP: `createdump`=1 for exactly one cycle → HALT. PC not advanced.
- HALT / ERROR: terminal until `rst`; all enables 0, `halted`=1; ERROR also `error`=1.
- `instret` increments by 1 on every cycle with `pc_we`=1; wraps 0xFFFFFFFF → 0. Halt instruction not counted.
- Outputs not listed for a state are 0; `alu_control` defaults to 000.

## Timing
- While `rst`=1 every output forced 0; first edge with `rst`=1 sets state=FETCH, `instret`=0, wait counter=0, `error`=0. Reset mid-access aborts immediately; no enable persists into the reset cycle.
- Wait counter clears on entry to FETCH and MEM; increments each cycle there without `mem_ready`. If `mem_ready`=0 in the cycle where counter = MEM_TIMEOUT−1 → ERROR next edge. `mem_ready`=1 in that same cycle wins (normal transition).
- `mem_ready` ignored outside FETCH/MEM.
- Latency with zero-wait memory: R/I 4 cycles, load 5, store 4, halt 3 cycles from FETCH to HALT (`createdump` in 3rd cycle). Each memory wait cycle adds 1.
- `instret` visible updated the cycle after `pc_we`.

## Test plan
- Reset then R-type ADD (opcode 0110011, funct3 000, funct7_5 0), `mem_ready` always 1 → state 0,1,2,4,0; `rf_we`/`pc_we` high in cycle 4 only; `alu_control`=000; `instret`=1.
- R-type SUB then I-type XOR (0010011, funct3 100) → EXEC `alu_control`=001 with `alu_src_b`=0, then 100 with `alu_src_b`=1; `instret`=2.
- Load with `mem_ready` delayed 3 cycles in MEM → MEM held 4 cycles, `mem_en`=1,`mem_wr`=0,`addr_sel`=1; then WB with `wb_sel`=1; store → `mem_wr`=1, `pc_we` in `mem_ready` cycle, no WB.
- MEM_TIMEOUT=4, `mem_ready` never asserted in FETCH → ERROR after exactly 4 FETCH cycles; `error`=`halted`=1; `mem_ready`=1 on 4th cycle instead → DECODE.
- `is_halt`=1 with opcode 0110011 → DUMP (`createdump` single pulse), HALT, `halted`=1, `instret` unchanged; opcode 1111111 → ERROR.
- Assert `rst` during MEM wait of a store → all outputs 0 during reset, state=FETCH, `instret`=0 after; normal fetch resumes.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle CPU control FSM. Sequences fetch, decode, execute,
//            memory and write-back one phase per clock, handshakes with memory,
//            handles halt/illegal/timeout and counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        is_halt,
  input  logic        mem_ready,
  output logic        mem_en,
  output logic        mem_wr,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        alu_src_b,
  output logic [2:0]  alu_control,
  output logic        createdump,
  output logic        halted,
  output logic        error,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  // Wait counter only needs to hold 0 .. MEM_TIMEOUT-1.
  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_DUMP   = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [31:0]   instret_q, instret_d;

  logic is_r, is_i, is_load, is_store, legal;
  logic [2:0] alu_dec;

  logic mem_en_int, mem_wr_int, addr_sel_int, ir_we_int, pc_we_int;
  logic rf_we_int, wb_sel_int, alu_src_b_int, createdump_int;
  logic [2:0] alu_control_int;

  // Instruction class and ALU operation decoded from the latched instruction.
  always_comb begin
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_I);
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    // R/I encodings with funct3=011 have no ALU mapping and decode as illegal.
    legal    = ((is_r || is_i) && (funct3 != 3'b011)) || is_load || is_store;
    alu_dec  = ALU_ADD;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_dec = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_dec = ALU_SLL;
        3'b010:  alu_dec = ALU_SLT;
        3'b100:  alu_dec = ALU_XOR;
        3'b101:  alu_dec = ALU_SRL;
        3'b110:  alu_dec = ALU_OR;
        3'b111:  alu_dec = ALU_AND;
        default: alu_dec = ALU_ADD;
      endcase
    end
  end

  // Next-state, wait-counter and per-state control outputs.
  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    mem_en_int      = 1'b0;
    mem_wr_int      = 1'b0;
    addr_sel_int    = 1'b0;
    ir_we_int       = 1'b0;
    pc_we_int       = 1'b0;
    rf_we_int       = 1'b0;
    wb_sel_int      = 1'b0;
    alu_src_b_int   = 1'b0;
    alu_control_int = ALU_ADD;
    createdump_int  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_en_int = 1'b1;
        if (mem_ready) begin
          ir_we_int = 1'b1;
          state_d   = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        // Halt wins over whatever the opcode field happens to hold.
        if (is_halt)    state_d = S_DUMP;
        else if (legal) state_d = S_EXEC;
        else            state_d = S_ERROR;
      end
      S_EXEC: begin
        alu_control_int = alu_dec;
        alu_src_b_int   = ~is_r;
        if (is_load || is_store) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_en_int    = 1'b1;
        addr_sel_int  = 1'b1;
        alu_src_b_int = 1'b1;
        mem_wr_int    = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we_int = 1'b1;
            state_d   = S_FETCH;
            wait_d    = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        rf_we_int  = 1'b1;
        pc_we_int  = 1'b1;
        wb_sel_int = is_load;
        state_d    = S_FETCH;
        wait_d     = '0;
      end
      S_DUMP: begin
        createdump_int = 1'b1;
        state_d        = S_HALT;
      end
      default: state_d = state_q;
    endcase
    instret_d = instret_q + 32'(pc_we_int);
  end

  // State, wait counter and retired-instruction counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  // Reset forces every output low immediately, aborting any access in flight.
  always_comb begin
    mem_en      = ~rst & mem_en_int;
    mem_wr      = ~rst & mem_wr_int;
    addr_sel    = ~rst & addr_sel_int;
    ir_we       = ~rst & ir_we_int;
    pc_we       = ~rst & pc_we_int;
    rf_we       = ~rst & rf_we_int;
    wb_sel      = ~rst & wb_sel_int;
    alu_src_b   = ~rst & alu_src_b_int;
    alu_control = rst ? 3'b000 : alu_control_int;
    createdump  = ~rst & createdump_int;
    halted      = ~rst & ((state_q == S_HALT) || (state_q == S_ERROR));
    error       = ~rst & (state_q == S_ERROR);
    state       = rst ? 3'b000 : state_q;
    instret     = rst ? 32'd0 : instret_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Scoreboard bench for multicycle_ctrl. Each driven cycle pushes its
//            expected state/controls/instret; a negedge monitor pops and checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 4;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_X = 3'd2, S_M = 3'd3;
  localparam logic [2:0] S_W = 3'd4, S_P = 3'd5, S_H = 3'd6, S_E = 3'd7;

  // Packed control view: {mem_en,mem_wr,addr_sel,ir_we,pc_we,rf_we,wb_sel,
  //                       alu_src_b,alu_control[2:0],createdump,halted,error}
  localparam logic [13:0] EN = 14'h2000, WR = 14'h1000, AS = 14'h0800;
  localparam logic [13:0] IR = 14'h0400, PC = 14'h0200, RF = 14'h0100;
  localparam logic [13:0] WB = 14'h0080, SB = 14'h0040, CD = 14'h0004;
  localparam logic [13:0] HL = 14'h0002, ER = 14'h0001;

  logic        clk, rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5, is_halt, mem_ready;
  logic        mem_en, mem_wr, addr_sel, ir_we, pc_we, rf_we, wb_sel, alu_src_b;
  logic [2:0]  alu_control;
  logic        createdump, halted, error;
  logic [2:0]  state;
  logic [31:0] instret;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [13:0] ctl;
    logic [31:0] ir;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_instret = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .is_halt(is_halt), .mem_ready(mem_ready),
    .mem_en(mem_en), .mem_wr(mem_wr), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .rf_we(rf_we), .wb_sel(wb_sel), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .createdump(createdump), .halted(halted),
    .error(error), .state(state), .instret(instret)
  );

  // Starts high so the first sample (negedge) precedes the first active edge.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] alu(input logic [2:0] a);
    return {8'd0, a, 3'd0};
  endfunction

  // Monitor: pop one expectation per cycle and compare away from the edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.tag, ".state"}, 32'(state), 32'(e.st));
      check({e.tag, ".ctl"},
            32'({mem_en, mem_wr, addr_sel, ir_we, pc_we, rf_we, wb_sel,
                 alu_src_b, alu_control, createdump, halted, error}),
            32'(e.ctl));
      check({e.tag, ".instret"}, instret, e.ir);
    end
  end

  // Drive one cycle of inputs and record what the DUT must show in it.
  task automatic cyc(input string tag, input logic r, input logic rdy,
                     input logic [2:0] st, input logic [13:0] ctl);
    exp_t e;
    rst       = r;
    mem_ready = rdy;
    e.tag = tag;
    e.st  = st;
    e.ctl = ctl;
    e.ir  = r ? 32'd0 : exp_instret;
    sb_q.push_back(e);
    if (r)            exp_instret = 0;
    else if (ctl & PC) exp_instret = exp_instret + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic h);
    opcode = op; funct3 = f3; funct7_5 = f7; is_halt = h;
  endtask

  // Zero-wait R/I-type instruction: FETCH, DECODE, EXEC, WB.
  task automatic alu_instr(input string tag, input logic [2:0] a, input logic imm);
    cyc({tag, "_f"}, 0, 1, S_F, EN | IR);
    cyc({tag, "_d"}, 0, 1, S_D, 14'd0);
    cyc({tag, "_x"}, 0, 1, S_X, alu(a) | (imm ? SB : 14'd0));
    cyc({tag, "_w"}, 0, 1, S_W, RF | PC);
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);

    cyc("rst0", 1, 1, S_F, 14'd0);
    cyc("rst1", 1, 0, S_F, 14'd0);

    // R ADD, R SUB, I XOR
    alu_instr("add", 3'b000, 0);
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    alu_instr("sub", 3'b001, 0);
    set_instr(7'b0010011, 3'b100, 1'b0, 1'b0);
    alu_instr("xori", 3'b100, 1);
    // I-type with funct7_5 set must not turn into SUB
    set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
    alu_instr("addi", 3'b000, 1);

    // Load with 3 wait cycles in MEM (ready on the last allowed cycle)
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    cyc("ld_f", 0, 1, S_F, EN | IR);
    cyc("ld_d", 0, 0, S_D, 14'd0);
    cyc("ld_x", 0, 0, S_X, SB);
    for (int i = 0; i < 3; i++) cyc("ld_mwait", 0, 0, S_M, EN | AS | SB);
    cyc("ld_m", 0, 1, S_M, EN | AS | SB);
    cyc("ld_w", 0, 0, S_W, RF | PC | WB);

    // Store with one wait cycle; PC advances in the ready cycle, no WB
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    cyc("st_f", 0, 1, S_F, EN | IR);
    cyc("st_d", 0, 1, S_D, 14'd0);
    cyc("st_x", 0, 1, S_X, SB);
    cyc("st_mwait", 0, 0, S_M, EN | WR | AS | SB);
    cyc("st_m", 0, 1, S_M, EN | WR | AS | SB | PC);

    // FETCH ready on the 4th cycle wins over timeout; I-type OR
    set_instr(7'b0010011, 3'b110, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("fw_wait", 0, 0, S_F, EN);
    cyc("fw_f", 0, 1, S_F, EN | IR);
    cyc("fw_d", 0, 1, S_D, 14'd0);
    cyc("fw_x", 0, 1, S_X, alu(3'b011) | SB);
    cyc("fw_w", 0, 1, S_W, RF | PC);

    // Store aborted by reset during its MEM wait
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    cyc("ra_f", 0, 1, S_F, EN | IR);
    cyc("ra_d", 0, 0, S_D, 14'd0);
    cyc("ra_x", 0, 0, S_X, SB);
    cyc("ra_mwait", 0, 0, S_M, EN | WR | AS | SB);
    cyc("ra_rst", 1, 1, S_F, 14'd0);
    set_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
    alu_instr("and", 3'b010, 0);

    // Halt decoded with an R opcode: DUMP pulse then HALT, instret unchanged
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b1);
    cyc("h_f", 0, 1, S_F, EN | IR);
    cyc("h_d", 0, 1, S_D, 14'd0);
    cyc("h_dump", 0, 1, S_P, CD);
    cyc("h_halt0", 0, 1, S_H, HL);
    cyc("h_halt1", 0, 1, S_H, HL);

    // Fetch timeout: 4 FETCH cycles without ready, then ERROR
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    cyc("to_rst", 1, 0, S_F, 14'd0);
    for (int i = 0; i < 4; i++) cyc("to_wait", 0, 0, S_F, EN);
    cyc("to_err0", 0, 1, S_E, HL | ER);
    cyc("to_err1", 0, 1, S_E, HL | ER);

    // Illegal opcode
    set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
    cyc("io_rst", 1, 0, S_F, 14'd0);
    cyc("io_f", 0, 1, S_F, EN | IR);
    cyc("io_d", 0, 1, S_D, 14'd0);
    cyc("io_err", 0, 1, S_E, HL | ER);

    // Illegal funct3=011 on R-type
    set_instr(7'b0110011, 3'b011, 1'b0, 1'b0);
    cyc("if3_rst", 1, 0, S_F, 14'd0);
    cyc("if3_f", 0, 1, S_F, EN | IR);
    cyc("if3_d", 0, 1, S_D, 14'd0);
    cyc("if3_err", 0, 0, S_E, HL | ER);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
